// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR MAC sequencer: state encoding, default
// geometry and saturation limits.
package fir_seq_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_TAPS  = 16;
  localparam int unsigned DEF_ACC_W = 40;
  localparam int unsigned DEF_FRAC  = 15;
  localparam int unsigned DEF_PIPE  = 2;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } state_t;

  // Largest positive / most negative two's-complement value for a w-bit result.
  function automatic logic [63:0] sat_pos_lim(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg_lim(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  localparam logic [DEF_WIDTH-1:0] SAT_POS = DEF_WIDTH'(64'h7FFF);
  localparam logic [DEF_WIDTH-1:0] SAT_NEG = DEF_WIDTH'(64'h8000);

endpackage

// File: rtl/fir_seq_dly.sv
// PIPE-deep shift register aligning tap-issue and first-tap flags with the
// product arriving at the MAC input.
module fir_seq_dly
  import fir_seq_pkg::*;
#(
  parameter int unsigned PIPE = DEF_PIPE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_issue,
  input  logic i_first,
  output logic o_mac_en,
  output logic o_mac_clr
);

  logic [PIPE-1:0] r_en_sr;
  logic [PIPE-1:0] r_clr_sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en_sr  <= '0;
      r_clr_sr <= '0;
    end else begin
      r_en_sr  <= PIPE'({r_en_sr, i_issue});
      r_clr_sr <= PIPE'({r_clr_sr, i_issue & i_first});
    end
  end

  assign o_mac_en  = r_en_sr[PIPE-1];
  assign o_mac_clr = r_clr_sr[PIPE-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one shared MAC across all FIR taps: delay-line write, per-tap address
// stepping, MAC clear/enable and registered result. FIR_SEQ_SAT_EN enables clamping.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned TAPS   = DEF_TAPS,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned FRAC   = DEF_FRAC,
  parameter int unsigned PIPE   = DEF_PIPE,
  localparam int unsigned ADDR_W = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              dl_we,
  output logic [ADDR_W-1:0] dl_waddr,
  output logic [WIDTH-1:0]  dl_wdata,
  output logic [ADDR_W-1:0] dl_raddr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_clr,
  output logic              mac_en,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_sat,
  output logic              busy
);

  localparam int unsigned CLR_W = ADDR_W + 1;
  localparam int unsigned DRN_W = (PIPE < 1) ? 1 : $clog2(PIPE + 1);
  localparam int unsigned MSB   = FRAC + WIDTH - 1;

  state_t            r_state, w_state;
  logic [CLR_W-1:0]  r_clr_cnt, w_clr_cnt;
  logic [ADDR_W-1:0] r_k, w_k;
  logic [DRN_W-1:0]  r_drn, w_drn;
  logic [ADDR_W-1:0] r_wp, w_wp;
  logic [ADDR_W-1:0] r_base, w_base;

  logic              r_in_ready, w_in_ready;
  logic              r_dl_we, w_dl_we;
  logic [ADDR_W-1:0] r_dl_waddr, w_dl_waddr;
  logic [WIDTH-1:0]  r_dl_wdata, w_dl_wdata;
  logic [ADDR_W-1:0] r_dl_raddr, w_dl_raddr;
  logic [ADDR_W-1:0] r_coef_addr, w_coef_addr;
  logic              r_issue, w_issue;
  logic              r_first, w_first;
  logic              r_out_valid, w_out_valid;
  logic [WIDTH-1:0]  r_out_data, w_out_data;
  logic              r_out_sat, w_out_sat;
  logic              r_busy, w_busy;

  logic [WIDTH-1:0]  w_res;
  logic              w_sat;
  logic [ADDR_W-1:0] w_k_nxt;
  logic              w_unused_acc;

  // Result extraction from the accumulator window
`ifdef FIR_SEQ_SAT_EN
  logic [ACC_W-1-MSB:0] w_hi;
  logic                 w_ovf;

  assign w_hi         = mac_acc[ACC_W-1:MSB];
  assign w_ovf        = !((&w_hi) || !(|w_hi));
  assign w_unused_acc = ^mac_acc[FRAC-1:0];

  always_comb begin
    w_sat = w_ovf;
    w_res = mac_acc[MSB:FRAC];
    if (w_ovf) begin
      w_res = mac_acc[ACC_W-1] ? WIDTH'(sat_neg_lim(WIDTH)) : WIDTH'(sat_pos_lim(WIDTH));
    end
  end
`else
  assign w_res        = mac_acc[MSB:FRAC];
  assign w_sat        = 1'b0;
  assign w_unused_acc = ^{mac_acc[ACC_W-1:MSB+1], mac_acc[FRAC-1:0]};
`endif

  assign w_k_nxt = r_k + ADDR_W'(1);

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    w_state     = r_state;
    w_clr_cnt   = r_clr_cnt;
    w_k         = r_k;
    w_drn       = r_drn;
    w_wp        = r_wp;
    w_base      = r_base;
    w_in_ready  = 1'b0;
    w_dl_we     = 1'b0;
    w_dl_waddr  = r_dl_waddr;
    w_dl_wdata  = r_dl_wdata;
    w_dl_raddr  = r_dl_raddr;
    w_coef_addr = r_coef_addr;
    w_issue     = 1'b0;
    w_first     = 1'b0;
    w_out_valid = r_out_valid;
    w_out_data  = r_out_data;
    w_out_sat   = r_out_sat;

    unique case (r_state)
      ST_CLEAR: begin
        if (r_clr_cnt == CLR_W'(TAPS)) begin
          w_state    = ST_IDLE;
          w_in_ready = 1'b1;
        end else begin
          w_dl_we    = 1'b1;
          w_dl_waddr = r_clr_cnt[ADDR_W-1:0];
          w_dl_wdata = '0;
          w_clr_cnt  = r_clr_cnt + CLR_W'(1);
        end
      end
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_state    = ST_WRITE;
          w_dl_we    = 1'b1;
          w_dl_waddr = r_wp;
          w_dl_wdata = in_data;
        end else begin
          w_in_ready = 1'b1;
        end
      end
      ST_WRITE: begin
        w_state     = ST_RUN;
        w_base      = r_wp;
        w_wp        = r_wp + ADDR_W'(1);
        w_k         = '0;
        w_coef_addr = '0;
        w_dl_raddr  = r_wp;
        w_issue     = 1'b1;
        w_first     = 1'b1;
      end
      ST_RUN: begin
        if (r_k == ADDR_W'(TAPS - 1)) begin
          w_state = ST_DRAIN;
          w_drn   = '0;
        end else begin
          w_k         = w_k_nxt;
          w_coef_addr = w_k_nxt;
          // Newest sample (base) pairs with coefficient 0
          w_dl_raddr  = r_base - w_k_nxt;
          w_issue     = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_drn == DRN_W'(PIPE)) begin
          w_state     = ST_OUT;
          w_out_valid = 1'b1;
          w_out_data  = w_res;
          w_out_sat   = w_sat;
        end else begin
          w_drn = r_drn + DRN_W'(1);
        end
      end
      ST_OUT: begin
        if (r_out_valid && out_ready) begin
          w_state     = ST_IDLE;
          w_out_valid = 1'b0;
          w_in_ready  = 1'b1;
        end
      end
      default: begin
        w_state = ST_CLEAR;
      end
    endcase

    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_CLEAR;
      r_clr_cnt   <= '0;
      r_k         <= '0;
      r_drn       <= '0;
      r_wp        <= '0;
      r_base      <= '0;
      r_in_ready  <= 1'b0;
      r_dl_we     <= 1'b0;
      r_dl_waddr  <= '0;
      r_dl_wdata  <= '0;
      r_dl_raddr  <= '0;
      r_coef_addr <= '0;
      r_issue     <= 1'b0;
      r_first     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_clr_cnt   <= w_clr_cnt;
      r_k         <= w_k;
      r_drn       <= w_drn;
      r_wp        <= w_wp;
      r_base      <= w_base;
      r_in_ready  <= w_in_ready;
      r_dl_we     <= w_dl_we;
      r_dl_waddr  <= w_dl_waddr;
      r_dl_wdata  <= w_dl_wdata;
      r_dl_raddr  <= w_dl_raddr;
      r_coef_addr <= w_coef_addr;
      r_issue     <= w_issue;
      r_first     <= w_first;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
      r_out_sat   <= w_out_sat;
      r_busy      <= w_busy;
    end
  end

  fir_seq_dly #(
    .PIPE(PIPE)
  ) u_dly (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_issue  (r_issue),
    .i_first  (r_first),
    .o_mac_en (mac_en),
    .o_mac_clr(mac_clr)
  );

  assign in_ready  = r_in_ready;
  assign dl_we     = r_dl_we;
  assign dl_waddr  = r_dl_waddr;
  assign dl_wdata  = r_dl_wdata;
  assign dl_raddr  = r_dl_raddr;
  assign coef_addr = r_coef_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: behavioural ROM/RAM/MAC around the DUT, a
// sum-of-products reference model and a queue-based output scoreboard.
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        dl_we;
  logic [3:0]  dl_waddr;
  logic [15:0] dl_wdata;
  logic [3:0]  dl_raddr;
  logic [3:0]  coef_addr;
  logic        mac_clr;
  logic        mac_en;
  logic [39:0] mac_acc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  fir_mac_sequencer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .dl_we(dl_we), .dl_waddr(dl_waddr), .dl_wdata(dl_wdata),
    .dl_raddr(dl_raddr), .coef_addr(coef_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_acc(mac_acc), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // External coefficient ROM, delay-line RAM and MAC
  logic signed [15:0] coef [16];
  logic signed [15:0] ram [16];
  logic signed [15:0] rd_q  = '0;
  logic signed [15:0] cf_q  = '0;
  logic signed [31:0] prod  = '0;
  logic signed [39:0] acc_m = '0;
  bit                 force_acc = 1'b0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      coef[i] = 16'((i + 1) * 1024);
      ram[i] <= 16'($urandom);
    end
  end

  always @(posedge clk) begin
    if (dl_we) ram[dl_waddr] <= dl_wdata;
    rd_q <= ram[dl_raddr];
    cf_q <= coef[coef_addr];
    prod <= rd_q * cf_q;
    if (mac_en) acc_m <= mac_clr ? 40'(prod) : acc_m + 40'(prod);
  end

  assign mac_acc = force_acc ? 40'h0080000000 : acc_m;

  // Reference model state: newest sample at hist[0]
  logic signed [15:0] hist [16];
  logic [3:0]         wp_m;

  typedef struct {
    logic [15:0] d;
    logic        s;
    int unsigned due;
  } exp_t;
  exp_t q[$];

  int rdy_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: compares every presented result against the scoreboard head
  initial begin
    bit          prev_ov = 1'b0;
    int unsigned en_cnt  = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_ov = 1'b0;
        en_cnt  = 0;
      end else begin
        if (mac_en) begin
          chk("mac_clr_first_tap", 64'(mac_clr), 64'(en_cnt == 0));
          en_cnt = (en_cnt + 1) % 16;
        end else if (mac_clr) begin
          chk("mac_clr_without_en", 64'(mac_clr), 64'(0));
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'(0));
          end else begin
            e = q[0];
            if (!prev_ov) chk("latency", 64'(cyc), 64'(e.due));
            chk("out_data_sat", 64'({out_sat, out_data}), 64'({e.s, e.d}));
            chk("in_ready_in_out", 64'(in_ready), 64'(0));
            if (out_ready) void'(q.pop_front());
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic reset_model();
    for (int i = 0; i < 16; i++) hist[i] = '0;
    wp_m = '0;
  endtask

  task automatic chk_clear();
    chk("reset_state", 64'({in_ready, dl_we, dl_waddr, dl_wdata, dl_raddr, coef_addr, mac_clr,
                             mac_en, out_valid, out_data, out_sat, busy}), 64'(0));
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("clear_write", 64'({dl_we, in_ready, busy, dl_waddr, dl_wdata}),
          64'({1'b1, 1'b0, 1'b1, 4'(k), 16'h0000}));
    end
    @(negedge clk);
    chk("clear_done", 64'({in_ready, dl_we, busy}), 64'(3'b100));
  endtask

  task automatic send(input logic [15:0] s, input bit frc, input bit abort7);
    int unsigned t = 0;
    longint      acc;
    longint      y;
    exp_t        e;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      t++;
      if (t > 400) begin
        chk("in_ready_timeout", 64'(in_ready), 64'(1));
        return;
      end
    end
    in_valid = 1'b1;
    in_data  = s;
    if (!abort7) begin
      for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = signed'(s);
      acc = 0;
      for (int k = 0; k < 16; k++) acc += longint'(coef[k]) * longint'(hist[k]);
      if (frc) acc = 64'sh80000000;
      y = acc >>> 15;
`ifdef FIR_SEQ_SAT_EN
      if (y > 32767) begin
        e.d = 16'h7FFF; e.s = 1'b1;
      end else if (y < -32768) begin
        e.d = 16'h8000; e.s = 1'b1;
      end else begin
        e.d = y[15:0];  e.s = 1'b0;
      end
`else
      e.d = y[15:0];
      e.s = 1'b0;
`endif
      e.due = cyc + 21;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    chk("write_cycle", 64'({dl_we, in_ready, busy, dl_waddr, dl_wdata}),
        64'({1'b1, 1'b0, 1'b1, wp_m, s}));
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("run_addr", 64'({coef_addr, dl_raddr}), 64'({4'(k), 4'(wp_m - 4'(k))}));
      if (abort7 && k == 7) begin
        reset_n = 1'b0;
        #1;
        chk("abort_outputs_zero", 64'({in_ready, dl_we, dl_waddr, dl_wdata, dl_raddr, coef_addr,
                                       mac_clr, mac_en, out_valid, out_data, out_sat, busy}),
            64'(0));
        return;
      end
    end
    wp_m = wp_m + 4'd1;
  endtask

  task automatic drain_wait();
    int unsigned t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    reset_model();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_clear();

    // Impulse response, then wrap of the write pointer
    send(16'h7FFF, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) send(16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(16'($urandom), 1'b0, 1'b0);
    drain_wait();

    // Downstream stall while a result is held
    rdy_mode = 2;
    send(16'($urandom), 1'b0, 1'b0);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid_seen", 64'(out_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", 64'({out_valid, in_ready, busy}), 64'(3'b101));
      @(negedge clk);
    end
    rdy_mode = 0;
    drain_wait();

    // Accumulator outside the output range
    force_acc = 1'b1;
    send(16'($urandom), 1'b1, 1'b0);
    drain_wait();
    force_acc = 1'b0;

    // Random samples with random downstream back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 24; i++) send(16'($urandom), 1'b0, 1'b0);
    drain_wait();
    rdy_mode = 0;

    // Reset in the middle of RUN
    send(16'($urandom), 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    reset_model();
    chk_clear();
    for (int i = 0; i < 6; i++) send(16'($urandom), 1'b0, 1'b0);
    drain_wait();

    chk("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
